multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Control FSM for the multi-cycle MIPS datapath; successor to the single-cycle combinational control unit.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK, one datapath step per cycle, stalling on a memory ready handshake.
- Drives all datapath mux selects, write enables and ALU op class.
- Counts retired instructions for performance monitoring.

Parameters:
- OPCODE_W, 6, opcode field width.
- CNT_W, 32, width of retired-instruction counter.
- JR_OPCODE, 6'b001000, team ISA opcode for jr.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  IR[31:26]; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes current request this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, qualified by mem_req.
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  PC update, branch condition already folded in.
- pc_src  out  2  PC source: 0=ALU(PC+4), 1=ALUOut(branch target), 2=jump target, 3=rs.
- reg_write  out  1  register file write.
- reg_dst  out  2  destination: 0=rt, 1=rd, 2=$31.
- mem_to_reg  out  2  write data: 0=ALUOut, 1=MDR, 2=PC, 3=imm<<16.
- alu_src_a  out  1  ALU A: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B: 0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- alu_op  out  2  ALU class: 0=add, 1=sub, 2=funct, 3=or (zero-ext imm).
- instr_done  out  1  one-cycle pulse when an instruction retires.
- retired_count  out  CNT_W  retired-instruction count.

Behaviour:
- States: FETCH, DECODE, EXEC_R, EXEC_ORI, EXEC_LUI, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP.
- Moore outputs are decoded from the registered state; unlisted outputs are 0 in every state.
- Reset: state=FETCH, retired_count=0. While reset is high, every output is 0 except the counter, which holds 0. Reset is honoured mid-instruction and aborts any pending memory request. FETCH issues its first request in the cycle after reset is released.
- FETCH:
  - Outputs: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE. Otherwise hold FETCH; ir_write and pc_write stay 0.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=0 (precomputes branch target).
  - Next state by opcode: 000000→EXEC_R; 100011/101011→MEM_ADDR; 000100/000101→BRANCH; 001101→EXEC_ORI; 001111→EXEC_LUI; 000010/000011/JR_OPCODE→JUMP; any other opcode → see Optional Feature.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2; next WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, retire; next FETCH.
- EXEC_ORI: alu_src_a=1, alu_src_b=2, alu_op=3; next WB_I.
- EXEC_LUI: no datapath action; next WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=3 for lui or 0 for ori (selected from opcode); retire; next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0; next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, i_or_d=1; hold until mem_ready=1, then WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, retire; next FETCH.
- MEM_WR: mem_req=1, mem_we=1, i_or_d=1; hold until mem_ready=1, then retire and go to FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1.
  - pc_write = zero for beq, ~zero for bne.
  - Retire; next FETCH.
- JUMP:
  - j: pc_write=1, pc_src=2.
  - jal: pc_write=1, pc_src=2, plus reg_write=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+4).
  - jr: pc_write=1, pc_src=3.
  - Retire; next FETCH.
- Retire means instr_done=1 for exactly that cycle and retired_count increments in the same cycle. The counter wraps from all-ones to 0 silently.
- Zero-wait latency in cycles (mem_ready always 1): R/ori/lui=4, lw=5, sw=4, beq/bne=3, j/jal/jr=3. Each memory wait cycle adds 1.
- mem_req, mem_we and i_or_d remain stable throughout a stall.

Optional Feature:
- Macro: MCCU_ILLEGAL_TRAP_EN.
- Defined:
  - Adds a TRAP state and an output port trap (1 bit, reset 0).
  - An unknown opcode in DECODE moves to TRAP. In TRAP: trap=1, all other outputs 0, no retire.
  - TRAP is left only by reset.
- Undefined:
  - An unknown opcode is a NOP: DECODE→FETCH, with instr_done pulsed and the counter incremented in the DECODE cycle.
  - No trap port.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode localparams;
  - state encoding, binary, 4 bits;
  - pc_src, reg_dst, mem_to_reg, alu_src_b and alu_op encodings.
- Sub-module mc_opcode_class: combinational opcode → one-hot class (rtype, lw, sw, beq, bne, ori, lui, j, jal, jr, illegal), instantiated once and shared by next-state and output logic.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 → cycle 1 after release in FETCH, mem_req=1, ir_write=1, pc_write=1; all outputs were 0 during reset.
- R-type (opcode 0), mem_ready=1 → states FETCH, DECODE, EXEC_R, WB_R; reg_write=1 with reg_dst=1 in cycle 4; instr_done pulses once; retired_count 0→1.
- lw with mem_ready low for 2 cycles in MEM_RD → 7 cycles total; mem_req/i_or_d stable during the stall; WB_MEM asserts mem_to_reg=1, reg_dst=0.
- beq with zero=1, then with zero=0; bne with zero=0 → pc_write=1, 0, 1 respectively in BRANCH, pc_src=1 each time.
- jal → JUMP asserts pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2. jr (001000) → pc_src=3, reg_write=0.
- Opcode 111111:
  - Trap build: trap=1 held indefinitely, retired_count unchanged; reset clears.
  - Non-trap build: back in FETCH after 2 cycles, counter +1.
- Reset asserted during a sw stall → next cycle state=FETCH, mem_we=0, and no retire or count increment is recorded.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states,
// datapath select codes and the one-hot opcode class bundle.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_ORI = 4'd3,
    ST_EXEC_LUI = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_WB_R     = 4'd8,
    ST_WB_I     = 4'd9,
    ST_WB_MEM   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_TRAP     = 4'd13
  } state_e;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] MTR_ALUOUT = 2'd0;
  localparam logic [1:0] MTR_MDR    = 2'd1;
  localparam logic [1:0] MTR_PC     = 2'd2;
  localparam logic [1:0] MTR_LUI    = 2'd3;

  localparam logic [1:0] ALUB_RT      = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_OR    = 2'd3;

  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic ori;
    logic lui;
    logic j;
    logic jal;
    logic jr;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode decoder producing a one-hot instruction class shared by
// the control FSM's next-state and output logic.
module mc_opcode_class
  import mc_ctrl_pkg::*;
#(
  parameter int                  OPCODE_W  = 6,
  parameter logic [OPCODE_W-1:0] JR_OPCODE = 6'b001000
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           cls
);

  always_comb begin
    cls         = '0;
    cls.rtype   = (opcode == OP_RTYPE);
    cls.lw      = (opcode == OP_LW);
    cls.sw      = (opcode == OP_SW);
    cls.beq     = (opcode == OP_BEQ);
    cls.bne     = (opcode == OP_BNE);
    cls.ori     = (opcode == OP_ORI);
    cls.lui     = (opcode == OP_LUI);
    cls.j       = (opcode == OP_J);
    cls.jal     = (opcode == OP_JAL);
    cls.jr      = (opcode == JR_OPCODE);
    cls.illegal = ~(cls.rtype | cls.lw | cls.sw | cls.beq | cls.bne | cls.ori |
                    cls.lui | cls.j | cls.jal | cls.jr);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with retired-instruction counter.
// Define MCCU_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of treating them as NOPs.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int                  OPCODE_W  = 6,
  parameter int                  CNT_W     = 32,
  parameter logic [OPCODE_W-1:0] JR_OPCODE = 6'b001000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
`ifdef MCCU_ILLEGAL_TRAP_EN
  output logic                trap,
`endif
  output logic                instr_done,
  output logic [CNT_W-1:0]    retired_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  op_class_t        cls;

  mc_opcode_class #(
    .OPCODE_W (OPCODE_W),
    .JR_OPCODE(JR_OPCODE)
  ) u_class (
    .opcode(opcode),
    .cls   (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done) count_q <= count_q + CNT_W'(1);
    end
  end

  assign retired_count = count_q;

  // Outputs are forced low while reset is high so an aborted access never
  // leaks a request or write strobe, regardless of the state being left.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = MTR_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_RT;
    alu_op     = ALUOP_ADD;
    instr_done = 1'b0;
`ifdef MCCU_ILLEGAL_TRAP_EN
    trap       = 1'b0;
`endif
    if (!reset) begin
      unique case (state_q)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = ALUB_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_src_b = ALUB_IMM_SH2;
          if (cls.rtype)                  state_d = ST_EXEC_R;
          else if (cls.lw | cls.sw)       state_d = ST_MEM_ADDR;
          else if (cls.beq | cls.bne)     state_d = ST_BRANCH;
          else if (cls.ori)               state_d = ST_EXEC_ORI;
          else if (cls.lui)               state_d = ST_EXEC_LUI;
          else if (cls.j | cls.jal | cls.jr) state_d = ST_JUMP;
          else begin
`ifdef MCCU_ILLEGAL_TRAP_EN
            state_d = ST_TRAP;
`else
            instr_done = 1'b1;
            state_d    = ST_FETCH;
`endif
          end
        end
        ST_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
          state_d   = ST_WB_R;
        end
        ST_WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = REG_DST_RD;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_EXEC_ORI: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
          alu_op    = ALUOP_OR;
          state_d   = ST_WB_I;
        end
        ST_EXEC_LUI: state_d = ST_WB_I;
        ST_WB_I: begin
          reg_write  = 1'b1;
          mem_to_reg = cls.lui ? MTR_LUI : MTR_ALUOUT;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
          state_d   = cls.sw ? ST_MEM_WR : ST_MEM_RD;
        end
        ST_MEM_RD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          if (mem_ready) state_d = ST_WB_MEM;
        end
        ST_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = MTR_MDR;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
        end
        ST_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALUOP_SUB;
          pc_src     = PC_SRC_ALUOUT;
          pc_write   = cls.bne ? ~zero : zero;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = cls.jr ? PC_SRC_RS : PC_SRC_JUMP;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
          if (cls.jal) begin
            reg_write  = 1'b1;
            reg_dst    = REG_DST_RA;
            mem_to_reg = MTR_PC;
          end
        end
`ifdef MCCU_ILLEGAL_TRAP_EN
        ST_TRAP: trap = 1'b1;
`endif
        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: stimulus pushes per-cycle expected control words, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        i_or_d;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        instr_done;
    logic        trap;
    logic [31:0] cnt;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, alu_src_a, instr_done;
  logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
  logic [31:0] retired_count;
  logic        trap_w;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  out_t exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .i_or_d       (i_or_d),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
`ifdef MCCU_ILLEGAL_TRAP_EN
    .trap         (trap_w),
`endif
    .instr_done   (instr_done),
    .retired_count(retired_count)
  );

`ifndef MCCU_ILLEGAL_TRAP_EN
  assign trap_w = 1'b0;
`endif

  out_t act;
  always_comb begin
    act            = '0;
    act.mem_req    = mem_req;
    act.mem_we     = mem_we;
    act.i_or_d     = i_or_d;
    act.ir_write   = ir_write;
    act.pc_write   = pc_write;
    act.pc_src     = pc_src;
    act.reg_write  = reg_write;
    act.reg_dst    = reg_dst;
    act.mem_to_reg = mem_to_reg;
    act.alu_src_a  = alu_src_a;
    act.alu_src_b  = alu_src_b;
    act.alu_op     = alu_op;
    act.instr_done = instr_done;
    act.trap       = trap_w;
    act.cnt        = retired_count;
  end

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", nm, act, e);
      end else begin
        $display("ok   %s: %h", nm, act);
      end
    end
  end

  // Expected control words per state, hand-derived from the state table.
  function automatic out_t o_idle();
    return '0;
  endfunction
  function automatic out_t o_fetch(input logic rdy);
    out_t v = '0;
    v.mem_req = 1; v.alu_src_b = 2'd1; v.ir_write = rdy; v.pc_write = rdy;
    return v;
  endfunction
  function automatic out_t o_decode(input logic nop);
    out_t v = '0;
    v.alu_src_b = 2'd3; v.instr_done = nop;
    return v;
  endfunction
  function automatic out_t o_exec_r();
    out_t v = '0;
    v.alu_src_a = 1; v.alu_src_b = 2'd0; v.alu_op = 2'd2;
    return v;
  endfunction
  function automatic out_t o_wb_r();
    out_t v = '0;
    v.reg_write = 1; v.reg_dst = 2'd1; v.instr_done = 1;
    return v;
  endfunction
  function automatic out_t o_exec_ori();
    out_t v = '0;
    v.alu_src_a = 1; v.alu_src_b = 2'd2; v.alu_op = 2'd3;
    return v;
  endfunction
  function automatic out_t o_wb_i(input logic lui);
    out_t v = '0;
    v.reg_write = 1; v.mem_to_reg = lui ? 2'd3 : 2'd0; v.instr_done = 1;
    return v;
  endfunction
  function automatic out_t o_mem_addr();
    out_t v = '0;
    v.alu_src_a = 1; v.alu_src_b = 2'd2;
    return v;
  endfunction
  function automatic out_t o_mem_rd();
    out_t v = '0;
    v.mem_req = 1; v.i_or_d = 1;
    return v;
  endfunction
  function automatic out_t o_wb_mem();
    out_t v = '0;
    v.reg_write = 1; v.mem_to_reg = 2'd1; v.instr_done = 1;
    return v;
  endfunction
  function automatic out_t o_mem_wr(input logic rdy);
    out_t v = '0;
    v.mem_req = 1; v.mem_we = 1; v.i_or_d = 1; v.instr_done = rdy;
    return v;
  endfunction
  function automatic out_t o_branch(input logic pcw);
    out_t v = '0;
    v.alu_src_a = 1; v.alu_op = 2'd1; v.pc_src = 2'd1; v.pc_write = pcw; v.instr_done = 1;
    return v;
  endfunction
  function automatic out_t o_jump(input logic [1:0] src, input logic link);
    out_t v = '0;
    v.pc_write = 1; v.pc_src = src; v.instr_done = 1;
    if (link) begin
      v.reg_write = 1; v.reg_dst = 2'd2; v.mem_to_reg = 2'd2;
    end
    return v;
  endfunction
  function automatic out_t o_trap();
    out_t v = '0;
    v.trap = 1;
    return v;
  endfunction

  // One clock cycle of stimulus plus its expected response.
  task automatic cyc(input logic rst, input logic rdy, input logic z,
                     input logic [5:0] op, input out_t v, input string nm);
    @(posedge clk);
    #1;
    reset = rst; mem_ready = rdy; zero = z; opcode = op;
    v.cnt = exp_cnt;
    exp_q.push_back(v);
    name_q.push_back(nm);
    if (v.instr_done) exp_cnt++;
    if (rst) exp_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 6'b000000, o_idle(), "reset_hold");

    // R-type
    cyc(0, 1, 0, 6'b000000, o_fetch(1),   "r_fetch");
    cyc(0, 1, 0, 6'b000000, o_decode(0),  "r_decode");
    cyc(0, 1, 0, 6'b000000, o_exec_r(),   "r_exec");
    cyc(0, 1, 0, 6'b000000, o_wb_r(),     "r_wb");
    // lw with two wait cycles in MEM_RD
    cyc(0, 1, 0, 6'b100011, o_fetch(1),   "lw_fetch");
    cyc(0, 1, 0, 6'b100011, o_decode(0),  "lw_decode");
    cyc(0, 1, 0, 6'b100011, o_mem_addr(), "lw_addr");
    cyc(0, 0, 0, 6'b100011, o_mem_rd(),   "lw_stall1");
    cyc(0, 0, 0, 6'b100011, o_mem_rd(),   "lw_stall2");
    cyc(0, 1, 0, 6'b100011, o_mem_rd(),   "lw_rd");
    cyc(0, 1, 0, 6'b100011, o_wb_mem(),   "lw_wb");
    // branches
    cyc(0, 1, 1, 6'b000100, o_fetch(1),   "beq1_fetch");
    cyc(0, 1, 1, 6'b000100, o_decode(0),  "beq1_decode");
    cyc(0, 1, 1, 6'b000100, o_branch(1),  "beq_taken");
    cyc(0, 1, 0, 6'b000100, o_fetch(1),   "beq0_fetch");
    cyc(0, 1, 0, 6'b000100, o_decode(0),  "beq0_decode");
    cyc(0, 1, 0, 6'b000100, o_branch(0),  "beq_not_taken");
    cyc(0, 1, 0, 6'b000101, o_fetch(1),   "bne_fetch");
    cyc(0, 1, 0, 6'b000101, o_decode(0),  "bne_decode");
    cyc(0, 1, 0, 6'b000101, o_branch(1),  "bne_taken");
    // ori / lui
    cyc(0, 1, 0, 6'b001101, o_fetch(1),    "ori_fetch");
    cyc(0, 1, 0, 6'b001101, o_decode(0),   "ori_decode");
    cyc(0, 1, 0, 6'b001101, o_exec_ori(),  "ori_exec");
    cyc(0, 1, 0, 6'b001101, o_wb_i(0),     "ori_wb");
    cyc(0, 1, 0, 6'b001111, o_fetch(1),    "lui_fetch");
    cyc(0, 1, 0, 6'b001111, o_decode(0),   "lui_decode");
    cyc(0, 1, 0, 6'b001111, o_idle(),      "lui_exec");
    cyc(0, 1, 0, 6'b001111, o_wb_i(1),     "lui_wb");
    // jumps
    cyc(0, 1, 0, 6'b000010, o_fetch(1),       "j_fetch");
    cyc(0, 1, 0, 6'b000010, o_decode(0),      "j_decode");
    cyc(0, 1, 0, 6'b000010, o_jump(2'd2, 0),  "j_jump");
    cyc(0, 1, 0, 6'b000011, o_fetch(1),       "jal_fetch");
    cyc(0, 1, 0, 6'b000011, o_decode(0),      "jal_decode");
    cyc(0, 1, 0, 6'b000011, o_jump(2'd2, 1),  "jal_jump");
    cyc(0, 1, 0, 6'b001000, o_fetch(1),       "jr_fetch");
    cyc(0, 1, 0, 6'b001000, o_decode(0),      "jr_decode");
    cyc(0, 1, 0, 6'b001000, o_jump(2'd3, 0),  "jr_jump");
    // sw with a fetch wait and a write wait
    cyc(0, 0, 0, 6'b101011, o_fetch(0),   "sw_fetch_wait");
    cyc(0, 1, 0, 6'b101011, o_fetch(1),   "sw_fetch");
    cyc(0, 1, 0, 6'b101011, o_decode(0),  "sw_decode");
    cyc(0, 1, 0, 6'b101011, o_mem_addr(), "sw_addr");
    cyc(0, 0, 0, 6'b101011, o_mem_wr(0),  "sw_stall");
    cyc(0, 1, 0, 6'b101011, o_mem_wr(1),  "sw_wr");
    // unknown opcode
    cyc(0, 1, 0, 6'b111111, o_fetch(1),   "ill_fetch");
`ifdef MCCU_ILLEGAL_TRAP_EN
    cyc(0, 1, 0, 6'b111111, o_decode(0),  "ill_decode");
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 6'b000000, o_trap(), "trap_hold");
    cyc(1, 1, 0, 6'b000000, o_idle(),     "trap_reset");
`else
    cyc(0, 1, 0, 6'b111111, o_decode(1),  "nop_decode");
`endif
    // reset during a sw write stall aborts the request without retiring
    cyc(0, 1, 0, 6'b101011, o_fetch(1),   "swr_fetch");
    cyc(0, 1, 0, 6'b101011, o_decode(0),  "swr_decode");
    cyc(0, 1, 0, 6'b101011, o_mem_addr(), "swr_addr");
    cyc(0, 0, 0, 6'b101011, o_mem_wr(0),  "swr_stall");
    cyc(1, 1, 0, 6'b101011, o_idle(),     "swr_reset");
    cyc(0, 1, 0, 6'b000000, o_fetch(1),   "post_reset_fetch");
    cyc(0, 1, 0, 6'b000000, o_decode(0),  "post_reset_decode");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
